// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types and constants for the 5-stage core hazard logic.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Operand source select for the Execute stage
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Result source encodings carried down the pipeline
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Hazard controller states (explicit 1-bit encoding)
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// ============================================================================
// Module      : fwd_sel
// Description : Per-operand forwarding comparator. The Memory stage holds the
//               younger result, so its match wins over Writeback. Register x0
//               is never forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel
  import riscv_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output fwd_sel_t   sel
);

  // Priority compare: Memory stage first, then Writeback, else register file
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
      sel = FWD_WB;
    end
  end

endmodule : fwd_sel
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller. Produces stall/flush enables for
//               the F/D, D/E, E/M and M/W registers, Execute-stage forwarding
//               selects, and freezes the pipeline while data memory is busy.
//               A saturating wait counter drives a sticky timeout flag.
//               Optional feature macro: HAZARD_PERF_CNT_EN (stall/flush
//               performance counters).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       rs1_d_i,
  input  logic [4:0]       rs2_d_i,
  input  logic [4:0]       rs1_e_i,
  input  logic [4:0]       rs2_e_i,
  input  logic [4:0]       rd_e_i,
  input  logic [1:0]       result_src_e_i,
  input  logic             pc_src_e_i,
  input  logic [4:0]       rd_m_i,
  input  logic             reg_write_m_i,
  input  logic             mem_req_m_i,
  input  logic             mem_ready_i,
  input  logic [4:0]       rd_w_i,
  input  logic             reg_write_w_i,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             stall_e_o,
  output logic             stall_m_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic             flush_w_o,
  output logic [1:0]       forward_a_e_o,
  output logic [1:0]       forward_b_e_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
`endif
  output logic             timeout_o
);

  localparam int               WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  hz_state_t         state;
  hz_state_t         state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lw_stall;
  logic              mem_stall;
  fwd_sel_t          fwd_a;
  fwd_sel_t          fwd_b;

  fwd_sel u_fwd_a (
    .rs_e        (rs1_e_i),
    .rd_m        (rd_m_i),
    .reg_write_m (reg_write_m_i),
    .rd_w        (rd_w_i),
    .reg_write_w (reg_write_w_i),
    .sel         (fwd_a)
  );

  fwd_sel u_fwd_b (
    .rs_e        (rs2_e_i),
    .rd_m        (rd_m_i),
    .reg_write_m (reg_write_m_i),
    .rd_w        (rd_w_i),
    .reg_write_w (reg_write_w_i),
    .sel         (fwd_b)
  );

  // Forwarding selects fall back to the register file while in reset
  assign forward_a_e_o = rst_i ? FWD_RF : fwd_a;
  assign forward_b_e_o = rst_i ? FWD_RF : fwd_b;

  // Load in Execute whose destination is read by the instruction in Decode
  assign lw_stall = (result_src_e_i == RES_MEM) && (rd_e_i != 5'd0) &&
                    ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

  // Memory not ready: either a fresh request missing this cycle or an ongoing wait.
  // The ready cycle itself is not a stall, so the pipeline advances with no delay.
  assign mem_stall = ((state == RUN) && mem_req_m_i && !mem_ready_i) ||
                     ((state == MEM_WAIT) && !mem_ready_i);

  // Next-state logic for the RUN / MEM_WAIT machine
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mem_req_m_i && !mem_ready_i) state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_ready_i)                 state_nxt = RUN;
      default:                                   state_nxt = RUN;
    endcase
  end

  // State register; reset aborts any wait in progress
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= RUN;
    else       state <= state_nxt;
  end

  // Pipeline control. A memory stall masks load-use and branch effects because
  // the frozen E stage presents them again on the ready cycle.
  always_comb begin
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    stall_e_o = 1'b0;
    stall_m_o = 1'b0;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;
    flush_w_o = 1'b0;
    if (rst_i) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
      flush_w_o = 1'b1;
    end else if (mem_stall) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      stall_e_o = 1'b1;
      stall_m_o = 1'b1;
      flush_w_o = 1'b1;
    end else begin
      // F/D gives clear priority over enable, so a branch flush wins over the
      // load-use hold when both occur together.
      stall_f_o = lw_stall;
      stall_d_o = lw_stall;
      flush_d_o = pc_src_e_i;
      flush_e_o = lw_stall | pc_src_e_i;
    end
  end

  // Saturating count of consecutive memory-stall cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (mem_stall) begin
      if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky timeout flag, cleared only by reset; stalling continues regardless
  always_ff @(posedge clk_i) begin
    if (rst_i)                     timeout_o <= 1'b0;
    else if (wait_cnt == WAIT_MAX) timeout_o <= 1'b1;
  end

`ifdef HAZARD_PERF_CNT_EN
  // Free-running wrap-around counters of fetch stalls and D/E flushes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_f_o) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (flush_e_o) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end
`endif

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4).
//               Exercises HAZARD_PERF_CNT_EN counters when that macro is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0] result_src_e;
  logic       pc_src_e, reg_write_m, mem_req_m, mem_ready, reg_write_w;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w, timeout;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  // Control bundle: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
  logic [6:0] ctl;
  assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl #(
    .MEM_TIMEOUT (4)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .CNT_W       (16)
`endif
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rs1_d_i        (rs1_d),
    .rs2_d_i        (rs2_d),
    .rs1_e_i        (rs1_e),
    .rs2_e_i        (rs2_e),
    .rd_e_i         (rd_e),
    .result_src_e_i (result_src_e),
    .pc_src_e_i     (pc_src_e),
    .rd_m_i         (rd_m),
    .reg_write_m_i  (reg_write_m),
    .mem_req_m_i    (mem_req_m),
    .mem_ready_i    (mem_ready),
    .rd_w_i         (rd_w),
    .reg_write_w_i  (reg_write_w),
    .stall_f_o      (stall_f),
    .stall_d_o      (stall_d),
    .stall_e_o      (stall_e),
    .stall_m_o      (stall_m),
    .flush_d_o      (flush_d),
    .flush_e_o      (flush_e),
    .flush_w_o      (flush_w),
    .forward_a_e_o  (fwd_a),
    .forward_b_e_o  (fwd_b),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt),
`endif
    .timeout_o      (timeout)
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    result_src_e = 2'b00; pc_src_e = 0; reg_write_m = 0; reg_write_w = 0;
    mem_req_m = 0; mem_ready = 0;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    rs1_e = 5; rd_m = 5; reg_write_m = 1;
    rs2_e = 6; rd_w = 6; reg_write_w = 1;
    #1;
    n_cmp++;
    if (ctl !== 7'b0000_111) begin
      $display("FAIL reset_ctl: got %b want %b", ctl, 7'b0000_111); n_err++;
    end
    n_cmp++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      $display("FAIL reset_fwd: got %b want %b", {fwd_a, fwd_b}, 4'b0000); n_err++;
    end
    tick(); tick();
    n_cmp++;
    if (timeout !== 1'b0) begin
      $display("FAIL reset_timeout: got %b want 0", timeout); n_err++;
    end
    rst = 0;
    set_idle();
    #1;
    n_cmp++;
    if (ctl !== 7'b0) begin
      $display("FAIL reset_release_ctl: got %b want %b", ctl, 7'b0); n_err++;
    end
  endtask

  task automatic test_forwarding();
    set_idle();
    rs1_e = 5; rs2_e = 5; rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1;
    #1;
    n_cmp++;
    if ({fwd_a, fwd_b} !== 4'b1010) begin
      $display("FAIL fwd_both_mem: got %b want %b", {fwd_a, fwd_b}, 4'b1010); n_err++;
    end
    reg_write_m = 0;
    #1;
    n_cmp++;
    if ({fwd_a, fwd_b} !== 4'b0101) begin
      $display("FAIL fwd_wb: got %b want %b", {fwd_a, fwd_b}, 4'b0101); n_err++;
    end
    reg_write_m = 1; rd_m = 0; rd_w = 0;
    #1;
    n_cmp++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      $display("FAIL fwd_x0: got %b want %b", {fwd_a, fwd_b}, 4'b0000); n_err++;
    end
    // Independent operands: A from Memory, B from Writeback
    rs1_e = 3; rs2_e = 9; rd_m = 3; rd_w = 9; reg_write_m = 1; reg_write_w = 1;
    #1;
    n_cmp++;
    if ({fwd_a, fwd_b} !== 4'b1001) begin
      $display("FAIL fwd_split: got %b want %b", {fwd_a, fwd_b}, 4'b1001); n_err++;
    end
    tick();
  endtask

  task automatic test_load_use();
    set_idle();
    result_src_e = 2'b01; rd_e = 7; rs2_d = 7;
    #1;
    n_cmp++;
    if (ctl !== 7'b1100_010) begin
      $display("FAIL lw_rs2: got %b want %b", ctl, 7'b1100_010); n_err++;
    end
    tick();
    rs2_d = 0; rs1_d = 7;
    #1;
    n_cmp++;
    if (ctl !== 7'b1100_010) begin
      $display("FAIL lw_rs1: got %b want %b", ctl, 7'b1100_010); n_err++;
    end
    tick();
    rd_e = 0; rs1_d = 0; rs2_d = 0;
    #1;
    n_cmp++;
    if (ctl !== 7'b0) begin
      $display("FAIL lw_x0: got %b want %b", ctl, 7'b0); n_err++;
    end
    result_src_e = 2'b00; rd_e = 7; rs2_d = 7;
    #1;
    n_cmp++;
    if (ctl !== 7'b0) begin
      $display("FAIL lw_not_load: got %b want %b", ctl, 7'b0); n_err++;
    end
    tick();
  endtask

  task automatic test_branch();
    set_idle();
    pc_src_e = 1;
    #1;
    n_cmp++;
    if (ctl !== 7'b0000_110) begin
      $display("FAIL branch_only: got %b want %b", ctl, 7'b0000_110); n_err++;
    end
    result_src_e = 2'b01; rd_e = 4; rs1_d = 4;
    #1;
    n_cmp++;
    if (ctl !== 7'b1100_110) begin
      $display("FAIL branch_lw: got %b want %b", ctl, 7'b1100_110); n_err++;
    end
    tick();
  endtask

  task automatic test_mem_wait();
    set_idle();
    mem_req_m = 1; mem_ready = 0; pc_src_e = 1;
    result_src_e = 2'b01; rd_e = 4; rs1_d = 4;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (ctl !== 7'b1111_001) begin
        $display("FAIL mem_wait_c%0d: got %b want %b", i, ctl, 7'b1111_001); n_err++;
      end
      tick();
      // Once waiting, the stall persists even without the request strobe
      mem_req_m = 0;
    end
    mem_ready = 1;
    result_src_e = 2'b00;
    #1;
    n_cmp++;
    if (ctl !== 7'b0000_110) begin
      $display("FAIL mem_ready_cycle: got %b want %b", ctl, 7'b0000_110); n_err++;
    end
    tick();
    set_idle();
    #1;
    n_cmp++;
    if (ctl !== 7'b0) begin
      $display("FAIL mem_back_to_run: got %b want %b", ctl, 7'b0); n_err++;
    end
    tick();
  endtask

  task automatic test_timeout();
    set_idle();
    mem_req_m = 1; mem_ready = 0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      n_cmp++;
      if (ctl !== 7'b1111_001) begin
        $display("FAIL to_stall_c%0d: got %b want %b", k, ctl, 7'b1111_001); n_err++;
      end
      tick();
      n_cmp++;
      if (timeout !== (k >= 5)) begin
        $display("FAIL to_flag_c%0d: got %b want %b", k, timeout, (k >= 5)); n_err++;
      end
    end
    mem_ready = 1;
    tick();
    set_idle();
    tick();
    n_cmp++;
    if (timeout !== 1'b1) begin
      $display("FAIL to_sticky: got %b want 1", timeout); n_err++;
    end
    rst = 1;
    tick();
    rst = 0;
    n_cmp++;
    if (timeout !== 1'b0) begin
      $display("FAIL to_reset_clear: got %b want 0", timeout); n_err++;
    end
  endtask

  task automatic test_reset_mid_wait();
    set_idle();
    mem_req_m = 1; mem_ready = 0;
    tick(); tick();
    rst = 1;
    rs1_e = 5; rd_m = 5; reg_write_m = 1;
    #1;
    n_cmp++;
    if ({ctl, fwd_a} !== 9'b0000_111_00) begin
      $display("FAIL rmw_in_reset: got %b want %b", {ctl, fwd_a}, 9'b0000_111_00); n_err++;
    end
    tick();
    rst = 0;
    set_idle();
    #1;
    n_cmp++;
    if (ctl !== 7'b0) begin
      $display("FAIL rmw_run_after: got %b want %b", ctl, 7'b0); n_err++;
    end
`ifdef HAZARD_PERF_CNT_EN
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== 32'd0) begin
      $display("FAIL rmw_perf_zero: got %0d/%0d want 0/0", stall_cnt, flush_cnt); n_err++;
    end
`endif
    // A cleared counter needs a full five stall cycles before timing out
    mem_req_m = 1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k >= 4) begin
        n_cmp++;
        if (timeout !== (k == 5)) begin
          $display("FAIL rmw_cnt_c%0d: got %b want %b", k, timeout, (k == 5)); n_err++;
        end
      end
    end
    set_idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    set_idle();
    rst = 1;
    tick();
    rst = 0;
    result_src_e = 2'b01; rd_e = 2; rs1_d = 2;   // load-use: stall + flush_e
    tick();
    set_idle();
    pc_src_e = 1;                                // branch: flush_e only
    tick();
    set_idle();
    mem_req_m = 1;                               // two memory-stall cycles
    tick(); tick();
    mem_ready = 1;
    tick();
    set_idle();
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== {16'd3, 16'd2}) begin
      $display("FAIL perf_counts: got %0d/%0d want 3/2", stall_cnt, flush_cnt); n_err++;
    end
  endtask
`endif

  initial begin
    set_idle();
    rst = 1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_hazard_ctrl
`default_nettype wire
